// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: widths for the multiplier/divider pair and the
// sequencer state encoding used by the divider.
package arith_pkg;

    // Multiplier operand and product widths; the divider inverts this product.
    localparam int MUL_AW = 16;
    localparam int MUL_BW = 16;
    localparam int MUL_PW = MUL_AW + MUL_BW;

    // Divider widths chosen so any multiplier product divides back by either factor.
    localparam int DIV_DW = MUL_PW;
    localparam int DIV_SW = MUL_BW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div32by16_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface div32by16_seq_if
    import arith_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int SW = DIV_SW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div32by16_seq_div_step.sv
// One restoring division iteration: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module div_step #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] pr_in,
    input  logic          dvd_msb,
    input  logic [SW-1:0] divisor,
    output logic [SW-1:0] pr_out,
    output logic          qbit
);
    logic [SW:0] shifted;
    logic [SW:0] diff;

    always_comb begin
        // NOTE: every output gets a value before any branch, so no path can infer a latch.
        shifted = {pr_in, dvd_msb};
        diff    = shifted - {1'b0, divisor};
        pr_out  = shifted[SW-1:0];
        qbit    = 1'b0;
        // pr_in < divisor keeps shifted below 2*divisor, so the borrow bit means "did not fit".
        if (!diff[SW]) begin
            pr_out = diff[SW-1:0];
            qbit   = 1'b1;
        end
    end
endmodule

// File: rtl/div32by16_seq.sv
// Sequential restoring divider: DW-bit dividend by SW-bit divisor, one quotient bit per clock,
// valid/ready handshakes on operand and result sides.
module div32by16_seq
    import arith_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int SW = DIV_SW
) (
    input  logic           clk,
    input  logic           rstn,
    div32by16_seq_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [SW-1:0] pr;
    logic [DW-1:0] dvd;
    logic [SW-1:0] dsr;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;
    logic [SW-1:0] step_pr;
    logic          step_q;

    div_step #(.SW(SW)) u_step (
        .pr_in   (pr),
        .dvd_msb (dvd[DW-1]),
        .divisor (dsr),
        .pr_out  (step_pr),
        .qbit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the working registers are reset as well; they are few flops and it keeps
            // them free of X after reset, at no cost to the result path.
            state       <= IDLE;
            count       <= '0;
            pr          <= '0;
            dvd         <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dsr         <= bus.divisor;
                        div_by_zero <= 1'b0;
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= bus.dividend[SW-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= BUSY;
                            count <= CW'(DW);
                            dvd   <= bus.dividend;
                            pr    <= '0;
                        end
                    end
                end
                BUSY: begin
                    pr    <= step_pr;
                    dvd   <= {dvd[DW-2:0], step_q};
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        quotient  <= {dvd[DW-2:0], step_q};
                        remainder <= step_pr;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule
